mips_lsu_ctrl: RTL

MIPS_LSU_CTRL -- requirements
Module: mips_lsu_ctrl

---
 rtl/mips_lsu_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mips_lsu_ctrl.sv
// MIPS load/store controller: one outstanding access, alignment checks, lane steering, load extension, bus timeout.
// Latency: 2 cycles accept-to-response with zero-wait memory; req_ready low (stall high) whenever not IDLE.
module mips_lsu_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_load,
   input  logic        req_store,
   input  logic [2:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        mem_en,
   output logic [29:0] mem_addr,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        exc_adel,
   output logic        exc_ades,
   output logic        exc_bus,
   output logic        stall
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic        load_q, load_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        adel_q, adel_d;
   logic        ades_q, ades_d;
   logic        bus_q, bus_d;

   logic        accept;
   logic        misaligned;
   logic [31:0] lane;
   logic [31:0] load_ext;

   assign accept = (state_q == IDLE) && req_valid && (req_load || req_store);

   always_comb begin
      misaligned = 1'b1;
      case (req_size)
         3'd1:    misaligned = 1'b0;
         3'd2:    misaligned = req_addr[0];
         3'd4:    misaligned = |req_addr[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   // Shift the addressed byte lane down to bit 0, then extend to 32 bits.
   assign lane = mem_rdata >> {addr_q[1:0], 3'b000};

   always_comb begin
      load_ext = lane;
      case (size_q)
         3'd1:    load_ext = {{24{signed_q & lane[7]}}, lane[7:0]};
         3'd2:    load_ext = {{16{signed_q & lane[15]}}, lane[15:0]};
         default: load_ext = lane;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      size_d   = size_q;
      signed_d = signed_q;
      load_d   = load_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      adel_d   = adel_q;
      ades_d   = ades_q;
      bus_d    = bus_q;
      case (state_q)
         IDLE: begin
            rdata_d = '0;
            adel_d  = 1'b0;
            ades_d  = 1'b0;
            bus_d   = 1'b0;
            if (accept) begin
               addr_d   = req_addr;
               size_d   = req_size;
               signed_d = req_signed;
               load_d   = req_load;
               wdata_d  = req_wdata;
               // Conflicting flags win over alignment so only one exception fires.
               if (req_load && req_store) begin
                  state_d = RESP;
                  bus_d   = 1'b1;
               end else if (misaligned) begin
                  state_d = RESP;
                  adel_d  = req_load;
                  ades_d  = req_store;
               end else begin
                  state_d = ACCESS;
                  cnt_d   = '0;
               end
            end
         end
         ACCESS: begin
            if (mem_ready) begin
               state_d = RESP;
               rdata_d = load_q ? load_ext : '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = RESP;
               bus_d   = 1'b1;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
            rdata_d = '0;
            adel_d  = 1'b0;
            ades_d  = 1'b0;
            bus_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         size_q   <= '0;
         signed_q <= 1'b0;
         load_q   <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         adel_q   <= 1'b0;
         ades_q   <= 1'b0;
         bus_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         load_q   <= load_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         adel_q   <= adel_d;
         ades_q   <= ades_d;
         bus_q    <= bus_d;
      end
   end

   // Memory-side outputs depend only on flops, so they stay constant through ACCESS.
   always_comb begin
      mem_we    = 4'b0000;
      mem_wdata = wdata_q;
      case (size_q)
         3'd1: begin
            mem_we    = 4'b0001 << addr_q[1:0];
            mem_wdata = {4{wdata_q[7:0]}};
         end
         3'd2: begin
            mem_we    = 4'b0011 << addr_q[1:0];
            mem_wdata = {2{wdata_q[15:0]}};
         end
         3'd4: mem_we = 4'b1111;
         default: mem_we = 4'b0000;
      endcase
      if ((state_q != ACCESS) || load_q) mem_we = 4'b0000;
   end

   assign mem_en     = (state_q == ACCESS);
   assign mem_addr   = addr_q[31:2];
   assign req_ready  = (state_q == IDLE);
   assign stall      = (state_q != IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = resp_valid ? rdata_q : '0;
   assign exc_adel   = resp_valid & adel_q;
   assign exc_ades   = resp_valid & ades_q;
   assign exc_bus    = resp_valid & bus_q;

endmodule
